// File: rtl/jk_modn_counter.sv
// ============================================================================
// jk_modn_counter : modulo-N up/down counter built from one jkff per count bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module jkff (
  input  logic clk,
  input  logic clr,
  input  logic pre,
  input  logic j,
  input  logic k,
  output logic q
);

  logic state_q;

  always_ff @(posedge clk or posedge clr or posedge pre) begin
    if (clr) begin
      state_q <= 1'b0;
    end else if (pre) begin
      state_q <= 1'b1;
    end else begin
      case ({j, k})
        2'b01:   state_q <= 1'b0;
        2'b10:   state_q <= 1'b1;
        2'b11:   state_q <= ~state_q;
        default: state_q <= state_q;
      endcase
    end
  end

  assign q = state_q;

endmodule

module jk_modn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("jk_modn_counter: WIDTH must be 1..16");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("jk_modn_counter: MODULUS must be 2..2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] jk_j;
  logic [WIDTH-1:0] jk_k;

  // Out-of-range values recover to 0 going up and to MAX_VAL going down.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = d;
    end else if (en) begin
      if (up) begin
        count_d = (count_q >= MAX_VAL) ? '0 : count_q + WIDTH'(1);
      end else begin
        count_d = (count_q == '0 || count_q > MAX_VAL) ? MAX_VAL
                                                        : count_q - WIDTH'(1);
      end
    end
  end

  assign jk_j = count_d & ~count_q;
  assign jk_k = ~count_d & count_q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jkff u_jkff (
        .clk (clk),
        .clr (clr),
        .pre (1'b0),
        .j   (jk_j[i]),
        .k   (jk_k[i]),
        .q   (count_q[i])
      );
    end
  endgenerate

  assign q  = count_q;
  assign tc = en & (up ? (count_q == MAX_VAL) : (count_q == '0));

endmodule

`default_nettype wire

// File: tb/tb_jk_modn_counter.sv
// ============================================================================
// tb_jk_modn_counter : decade, cascaded-decade and binary counters vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jk_modn_counter;

  logic clk = 1'b0;
  logic clr = 1'b1;

  logic       a_en = 0, a_up = 0, a_load = 0;
  logic [3:0] a_d = 0;
  logic [3:0] a_q;
  logic       a_tc;

  logic       c_en = 0, c_up = 0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c1_tc;

  logic       b_en = 0, b_up = 0, b_load = 0;
  logic [3:0] b_d = 0;
  logic [3:0] b_q;
  logic       b_tc;

  int n_pass = 0;
  int n_total = 0;

  int m_a = 0;
  int m_b = 0;
  int m_c = 0;

  always #5 clk = ~clk;

  jk_modn_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk(clk), .clr(clr), .en(a_en), .up(a_up), .load(a_load), .d(a_d),
    .q(a_q), .tc(a_tc));

  jk_modn_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
    .clk(clk), .clr(clr), .en(c_en), .up(c_up), .load(1'b0), .d(4'd0),
    .q(c0_q), .tc(c0_tc));

  jk_modn_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
    .clk(clk), .clr(clr), .en(c0_tc), .up(c_up), .load(1'b0), .d(4'd0),
    .q(c1_q), .tc(c1_tc));

  jk_modn_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk(clk), .clr(clr), .en(b_en), .up(b_up), .load(b_load), .d(b_d),
    .q(b_q), .tc(b_tc));

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Next value from the counting rules: modular step in range, snap otherwise.
  function automatic int nxt(input int q, input int m, input bit ld,
                             input int dv, input bit en, input bit up);
    if (ld) return dv;
    if (!en) return q;
    if (q >= m) return up ? 0 : m - 1;
    return up ? (q + 1) % m : (q + m - 1) % m;
  endfunction

  function automatic int tc_of(input int q, input int m, input bit en, input bit up);
    return (en && ((up && q == m - 1) || (!up && q == 0))) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_a <= 0;
      m_b <= 0;
      m_c <= 0;
    end else begin
      m_a <= nxt(m_a, 10, a_load, int'(a_d), a_en, a_up);
      m_b <= nxt(m_b, 16, b_load, int'(b_d), b_en, b_up);
      if (c_en) m_c <= c_up ? (m_c + 1) % 100 : (m_c + 99) % 100;
    end
  end

  always @(negedge clk) begin
    chk("dec_q", int'(a_q), m_a);
    chk("dec_tc", int'(a_tc), tc_of(m_a, 10, a_en, a_up));
    chk("bin_q", int'(b_q), m_b);
    chk("bin_tc", int'(b_tc), tc_of(m_b, 16, b_en, b_up));
    chk("cas_lo", int'(c0_q), m_c % 10);
    chk("cas_hi", int'(c1_q), m_c / 10);
    chk("cas_tc0", int'(c0_tc), tc_of(m_c % 10, 10, c_en, c_up));
    chk("cas_tc1", int'(c1_tc), tc_of(m_c, 100, c_en, c_up));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    #1 clr = 1'b1;
    #1 clr = 1'b0;
  endtask

  int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int dn_seq[4]   = '{9, 8, 7, 6};

  initial begin
    repeat (2) step();
    clr = 1'b0;
    chk("rst_q", int'(a_q), 0);
    chk("rst_tc", int'(a_tc), 0);

    // Asynchronous clear from 7, held across edges, then first count
    a_load = 1; a_d = 4'd7;
    step();
    chk("load7", int'(a_q), 7);
    a_load = 0;
    #2 clr = 1'b1;
    #1 chk("midclr_q", int'(a_q), 0);
    a_en = 1; a_up = 1;
    step(); step();
    chk("clr_held", int'(a_q), 0);
    clr = 1'b0;
    step();
    chk("first_cnt", int'(a_q), 1);

    pulse_clr();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("up_seq", int'(a_q), up_seq[i]);
      chk("up_tc", int'(a_tc), (up_seq[i] == 9) ? 1 : 0);
    end

    pulse_clr();
    a_up = 0;
    #1 chk("dn_rst_tc", int'(a_tc), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_seq", int'(a_q), dn_seq[i]);
      chk("dn_tc", int'(a_tc), 0);
    end

    a_load = 1; a_d = 4'd4; a_up = 1;
    step();
    chk("load_over_en", int'(a_q), 4);
    a_d = 4'd13;
    step();
    chk("load13", int'(a_q), 13);
    a_load = 0;
    step();
    chk("oor_up", int'(a_q), 0);
    a_load = 1;
    step();
    a_load = 0; a_up = 0;
    step();
    chk("oor_dn", int'(a_q), 9);
    a_en = 0;

    pulse_clr();
    c_en = 1; c_up = 1;
    repeat (25) step();
    chk("cas_25_hi", int'(c1_q), 2);
    chk("cas_25_lo", int'(c0_q), 5);
    c_en = 0;

    b_load = 1; b_d = 4'd15; b_en = 1; b_up = 1;
    step();
    chk("bin_load15", int'(b_q), 15);
    b_load = 0;
    step();
    chk("bin_wrap_up", int'(b_q), 0);
    b_up = 0;
    step();
    chk("bin_wrap_dn", int'(b_q), 15);
    b_en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bin_hold", int'(b_q), 15);
      chk("bin_hold_tc", int'(b_tc), 0);
    end

    for (int i = 0; i < 400; i++) begin
      a_load = ($urandom_range(7) == 0);
      a_en   = ($urandom_range(3) != 0);
      a_up   = 1'($urandom_range(1));
      a_d    = 4'($urandom_range(15));
      b_load = ($urandom_range(7) == 0);
      b_en   = ($urandom_range(3) != 0);
      b_up   = 1'($urandom_range(1));
      b_d    = 4'($urandom_range(15));
      c_en   = ($urandom_range(3) != 0);
      c_up   = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) pulse_clr();
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
